// File: rtl/lock_pkg.sv
// Shared definitions for the code-lock front end: FSM state encoding and
// default parameter values used by key_code_entry and its testbench.
package lock_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int DIGIT_W_DEF     = 4;
  localparam int MAX_TRIES_DEF   = 3;
  localparam int LOCK_CYCLES_DEF = 100;

  // State encoding kept as plain constants so legacy tools and waveform
  // scripts that match on raw values keep working.
  typedef logic [1:0] state_t;
  localparam state_t ST_ENTRY   = 2'd0;
  localparam state_t ST_CHECK   = 2'd1;
  localparam state_t ST_OPEN    = 2'd2;
  localparam state_t ST_LOCKOUT = 2'd3;

endpackage

// File: rtl/key_code_entry_if.sv
// Keypad/comparator bundle for key_code_entry. The slave side is the entry
// block itself; the master side is the keypad plus the external comparator.
interface key_code_entry_if #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 4
);
  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(NDIG + 1);

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               submit;
  logic               clear;
  logic               cmp_res;
  logic [WIDTH-1:0]   entry;
  logic [CNT_W-1:0]   digit_cnt;
  logic               unlocked;
  logic               fail;
  logic               locked;

  modport master (
    output digit_valid, digit, submit, clear, cmp_res,
    input  entry, digit_cnt, unlocked, fail, locked
  );

  modport slave (
    input  digit_valid, digit, submit, clear, cmp_res,
    output entry, digit_cnt, unlocked, fail, locked
  );
endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter that times the lockout period. done is high whenever
// the count is zero; the count holds at zero instead of wrapping.
module lockout_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/key_code_entry.sv
// Sequential front end of the code lock: shifts keypad digits into a code
// word for the external comparator, checks one attempt per submit, counts
// consecutive failures and holds a timed lockout after too many of them.
module key_code_entry
  import lock_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int MAX_TRIES   = MAX_TRIES_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  key_code_entry_if.slave bus
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NDIG);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

  state_t           state;
  logic [WIDTH-1:0] entry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TRY_W-1:0] tries;
  logic             fail_q;

  logic             match;
  logic [TRY_W-1:0] tries_inc;
  logic             lock_now;
  logic             tmr_done;

  // Attempt evaluation: a short entry never matches, and the try counter
  // saturates rather than wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    match     = 1'b0;
    tries_inc = tries;
    lock_now  = 1'b0;
    match     = (cnt_q == FULL_CNT) && bus.cmp_res;
    if (tries != TRY_LIMIT) begin
      tries_inc = tries + TRY_W'(1);
    end
    lock_now = (state == ST_CHECK) && !match && (tries_inc == TRY_LIMIT);
  end

  lockout_timer #(
    .W (TMR_W)
  ) u_lockout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lock_now),
    .load_val (LOCK_LOAD),
    .dec      (state == ST_LOCKOUT),
    .done     (tmr_done)
  );

  // Main FSM with the digit shift register, try counter and fail pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_ENTRY;
      entry_q <= '0;
      cnt_q   <= '0;
      tries   <= '0;
      fail_q  <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (bus.clear) begin
            entry_q <= '0;
            cnt_q   <= '0;
          end else if (bus.submit) begin
            state <= ST_CHECK;
          end else if (bus.digit_valid && cnt_q < FULL_CNT) begin
            entry_q <= (entry_q << DIGIT_W) | WIDTH'(bus.digit);
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          entry_q <= '0;
          cnt_q   <= '0;
          if (match) begin
            state <= ST_OPEN;
            tries <= '0;
          end else begin
            fail_q <= 1'b1;
            tries  <= tries_inc;
            state  <= lock_now ? ST_LOCKOUT : ST_ENTRY;
          end
        end
        ST_OPEN: begin
          if (bus.clear) begin
            state <= ST_ENTRY;
          end
        end
        ST_LOCKOUT: begin
          if (tmr_done) begin
            state <= ST_ENTRY;
            tries <= '0;
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

  assign bus.entry     = entry_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.fail      = fail_q;
  assign bus.unlocked  = (state == ST_OPEN);
  assign bus.locked    = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_key_code_entry.sv
// Self-checking bench for key_code_entry: a vector table for single-cycle
// behaviour plus hand-written sequences for lockout, try reset and reset.
module tb_key_code_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] stored = 8'h37;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  key_code_entry_if #(.WIDTH(8), .DIGIT_W(4)) bus ();

  // Stand-in for the external equality comparator.
  assign bus.cmp_res = (bus.entry == stored);

  key_code_entry #(
    .WIDTH       (8),
    .DIGIT_W     (4),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       sub;
    logic       clr;
    logic [7:0] e_entry;
    logic [1:0] e_cnt;
    logic       e_unl;
    logic       e_fail;
    logic       e_lck;
  } vec_t;

  vec_t vec [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e, input logic [1:0] c,
                           input logic u, input logic f, input logic l);
    check({tag, " entry"},     32'(bus.entry),     32'(e));
    check({tag, " digit_cnt"}, 32'(bus.digit_cnt), 32'(c));
    check({tag, " unlocked"},  32'(bus.unlocked),  32'(u));
    check({tag, " fail"},      32'(bus.fail),      32'(f));
    check({tag, " locked"},    32'(bus.locked),    32'(l));
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge, drop strobes.
  task automatic cycle(input logic dv, input logic [3:0] d, input logic sub, input logic clr);
    @(negedge clk);
    bus.digit_valid = dv;
    bus.digit       = d;
    bus.submit      = sub;
    bus.clear       = clr;
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'h0;
    bus.submit      = 1'b0;
    bus.clear       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Two digits, submit, one more cycle: returns at the result sample (t+1).
  task automatic attempt(input logic [3:0] d0, input logic [3:0] d1);
    cycle(1'b1, d0, 1'b0, 1'b0);
    cycle(1'b1, d1, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lock_len;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'h0;
    bus.submit      = 1'b0;
    bus.clear       = 1'b0;

    //            dv    d     sub   clr   entry  cnt   unl   fail  lck
    vec[0]  = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 4'h3, 1'b0, 1'b0, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 4'h7, 1'b0, 1'b0, 8'h37, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 4'h9, 1'b0, 1'b0, 8'h37, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h37, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 4'h5, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b1, 4'h3, 1'b0, 1'b0, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0};
    vec[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 4'h3, 1'b0, 1'b0, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0};
    vec[15] = '{1'b1, 4'h7, 1'b0, 1'b0, 8'h37, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[16] = '{1'b1, 4'h5, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    vec[17] = '{1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};

    // Reset state, sampled while rst is still asserted.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table: match/open/clear, dropped extra digit, short entry, strobe priority.
    for (int i = 0; i < 18; i++) begin
      cycle(vec[i].dv, vec[i].d, vec[i].sub, vec[i].clr);
      check_all($sformatf("vec%0d", i), vec[i].e_entry, vec[i].e_cnt,
                vec[i].e_unl, vec[i].e_fail, vec[i].e_lck);
    end

    // Short entry fails even when the comparator reports equality.
    stored = 8'h03;
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check("short cmp_res", 32'(bus.cmp_res), 32'd1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_all("short", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    stored = 8'h37;

    // A match clears the try count: fail, fail, match, fail must not lock.
    do_reset();
    attempt(4'h3, 4'h8);
    attempt(4'h3, 4'h8);
    attempt(4'h3, 4'h7);
    check("tryreset open", 32'(bus.unlocked), 32'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    attempt(4'h3, 4'h8);
    check_all("tryreset fail", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);

    // Three failures lock for exactly 100 cycles, inputs ignored meanwhile.
    do_reset();
    attempt(4'h3, 4'h8);
    check_all("lk fail1", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check("lk fail1 pulse end", 32'(bus.fail), 32'd0);
    attempt(4'h3, 4'h8);
    check_all("lk fail2", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    attempt(4'h3, 4'h8);
    check_all("lk fail3", 8'h00, 2'd0, 1'b0, 1'b1, 1'b1);
    lock_len = 1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 4'h5, (i % 7) == 3, (i % 11) == 5);
      if (!bus.locked) break;
      lock_len++;
    end
    check("lk length", 32'(lock_len), 32'd100);
    check_all("lk exit", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check_all("lk first digit", 8'h03, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check_all("lk tries cleared", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a lockout.
    do_reset();
    attempt(4'h3, 4'h8);
    attempt(4'h3, 4'h8);
    attempt(4'h3, 4'h8);
    check("rl locked", 32'(bus.locked), 32'd1);
    repeat (39) cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check("rl still locked", 32'(bus.locked), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all("rl async", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check_all("rl first digit", 8'h03, 2'd1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
